// File: rtl/fwd_source_pkg.sv
// fwd_source_pkg: shared types for the decode-side bypass producer.
//   NREG / XLEN    : architectural register count and word width
//   creg_addr_t    : register address
//   word_t         : data word
//   stage_fwd_t    : per-stage forwarding record {valid, dst, wen, ismem, val}
package fwd_source_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned XLEN = 64;

  typedef logic [4:0]      creg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    logic       valid;
    creg_addr_t dst;
    logic       wen;
    logic       ismem;
    word_t      val;
  } stage_fwd_t;

endpackage

// File: rtl/fwd_source_regfile.sv
// fwd_source_regfile: NREG x XLEN architectural register file.
//   clk, reset : clock, asynchronous active-low reset (clears every entry)
//   ra1, ra2   : read addresses; rd1, rd2 combinational read data
//   we, wa, wd : write enable / address / data, sampled on the rising edge
// x0 reads as zero and ignores writes. No write-to-read bypass.
module fwd_source_regfile
  import fwd_source_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  creg_addr_t ra1,
  input  creg_addr_t ra2,
  output word_t      rd1,
  output word_t      rd2,
  input  logic       we,
  input  creg_addr_t wa,
  input  word_t      wd
);

  word_t regs [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = (ra1 == '0) ? '0 : regs[ra1];
    rd2 = (ra2 == '0) ? '0 : regs[ra2];
  end

endmodule

// File: rtl/fwd_source.sv
// fwd_source: producer side of the decode-stage operand bypass.
// Carries destination info through E/M/W, retires W into the register file,
// and drives per-stage dst/rd/bubble, writeM/W and ismemE for the bypass mux.
//   clk, reset              : clock, asynchronous active-low reset
//   id_valid/dst/wen/ismem  : instruction issued by decode
//   hazard, flush           : load-use bubble request, branch redirect
//   ex_result               : value computed by E this cycle
//   mem_rdata, mem_rvalid   : load data for the M-stage load and its valid
//   ra1, ra2 / scr1, scr2   : register-file read addresses / data
//   dstE/M/W, rdE/M/W       : stage destinations and forwardable values
//   bubbleE/M/W             : stage holds no valid instruction
//   writeM, writeW          : stage will write a nonzero register
//   ismemE                  : E-stage instruction is a load
//   mem_stall               : pipeline frozen waiting for load data
//   instret                 : retired-instruction counter
module fwd_source
  import fwd_source_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  creg_addr_t  id_dst,
  input  logic        id_wen,
  input  logic        id_ismem,
  input  logic        hazard,
  input  logic        flush,
  input  word_t       ex_result,
  input  word_t       mem_rdata,
  input  logic        mem_rvalid,
  input  creg_addr_t  ra1,
  input  creg_addr_t  ra2,
  output word_t       scr1,
  output word_t       scr2,
  output creg_addr_t  dstE,
  output creg_addr_t  dstM,
  output creg_addr_t  dstW,
  output word_t       rdE,
  output word_t       rdM,
  output word_t       rdW,
  output logic        bubbleE,
  output logic        bubbleM,
  output logic        bubbleW,
  output logic        writeM,
  output logic        writeW,
  output logic        ismemE,
  output logic        mem_stall,
  output logic [63:0] instret
);

  stage_fwd_t e, m, w;
  logic       pend_flush;
  logic       advance;

  assign mem_stall = m.valid & m.ismem & ~mem_rvalid;
  assign advance   = ~mem_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e          <= '0;
      m          <= '0;
      w          <= '0;
      pend_flush <= 1'b0;
      instret    <= '0;
    end else if (advance) begin
      w <= m;
      if (m.ismem) w.val <= mem_rdata;
      m     <= e;
      m.val <= ex_result;
      // A flush that arrived while frozen is honoured on this first advance.
      e.valid    <= id_valid & ~hazard & ~(flush | pend_flush);
      e.dst      <= id_dst;
      e.wen      <= id_wen;
      e.ismem    <= id_ismem;
      e.val      <= '0;
      pend_flush <= 1'b0;
      if (w.valid) instret <= instret + 64'd1;
    end else if (flush) begin
      pend_flush <= 1'b1;
    end
  end

  assign dstE    = e.dst;
  assign dstM    = m.dst;
  assign dstW    = w.dst;
  assign rdE     = ex_result;
  assign rdM     = m.val;
  assign rdW     = w.val;
  assign bubbleE = ~e.valid;
  assign bubbleM = ~m.valid;
  assign bubbleW = ~w.valid;
  assign writeM  = m.valid & m.wen & (m.dst != '0);
  assign writeW  = w.valid & w.wen & (w.dst != '0);
  assign ismemE  = e.valid & e.ismem;

  // E never holds a result and W's load flag has no consumer.
  logic unused;
  assign unused = ^{e.val, w.ismem};

  fwd_source_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (scr1),
    .rd2   (scr2),
    .we    (writeW),
    .wa    (w.dst),
    .wd    (w.val)
  );

endmodule

// File: tb/tb_fwd_source.sv
module tb_fwd_source;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_dst;
  logic        id_wen;
  logic        id_ismem;
  logic        hazard;
  logic        flush;
  logic [63:0] ex_result;
  logic [63:0] mem_rdata;
  logic        mem_rvalid;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [63:0] scr1;
  logic [63:0] scr2;
  logic [4:0]  dstE;
  logic [4:0]  dstM;
  logic [4:0]  dstW;
  logic [63:0] rdE;
  logic [63:0] rdM;
  logic [63:0] rdW;
  logic        bubbleE;
  logic        bubbleM;
  logic        bubbleW;
  logic        writeM;
  logic        writeW;
  logic        ismemE;
  logic        mem_stall;
  logic [63:0] instret;

  int total = 0;
  int bad   = 0;

  fwd_source dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_dst     (id_dst),
    .id_wen     (id_wen),
    .id_ismem   (id_ismem),
    .hazard     (hazard),
    .flush      (flush),
    .ex_result  (ex_result),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .ra1        (ra1),
    .ra2        (ra2),
    .scr1       (scr1),
    .scr2       (scr2),
    .dstE       (dstE),
    .dstM       (dstM),
    .dstW       (dstW),
    .rdE        (rdE),
    .rdM        (rdM),
    .rdW        (rdW),
    .bubbleE    (bubbleE),
    .bubbleM    (bubbleM),
    .bubbleW    (bubbleW),
    .writeM     (writeM),
    .writeW     (writeW),
    .ismemE     (ismemE),
    .mem_stall  (mem_stall),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the in-flight instructions as a 3-entry queue,
  // index 0 = youngest (E), index 2 = oldest (W).
  typedef struct {
    bit        v;
    bit [4:0]  d;
    bit        wen;
    bit        ld;
    bit [63:0] val;
  } mstg_t;

  mstg_t     pipe[$];
  bit [63:0] mrf [32];
  bit [63:0] mret;
  bit        owed_kill;

  task automatic model_reset();
    mstg_t blank;
    blank = '{v: 1'b0, d: 5'd0, wen: 1'b0, ld: 1'b0, val: 64'd0};
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(blank);
    for (int i = 0; i < 32; i++) mrf[i] = 64'd0;
    mret      = 64'd0;
    owed_kill = 1'b0;
  endtask

  function automatic bit model_frozen();
    return pipe[1].v && pipe[1].ld && !mem_rvalid;
  endfunction

  task automatic model_step();
    mstg_t oldest, fresh;
    bit    frozen;
    frozen = model_frozen();
    oldest = pipe[2];
    if (oldest.v && oldest.wen && oldest.d != 5'd0) mrf[oldest.d] = oldest.val;
    if (!frozen) begin
      if (oldest.v) mret = mret + 64'd1;
      void'(pipe.pop_back());
      if (pipe[1].ld) pipe[1].val = mem_rdata;
      pipe[0].val = ex_result;
      fresh.v   = id_valid && !hazard && !(flush || owed_kill);
      fresh.d   = id_dst;
      fresh.wen = id_wen;
      fresh.ld  = id_ismem;
      fresh.val = 64'd0;
      pipe.push_front(fresh);
      owed_kill = 1'b0;
    end else if (flush) begin
      owed_kill = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bubbleE", 64'(bubbleE), 64'(!pipe[0].v));
    chk("bubbleM", 64'(bubbleM), 64'(!pipe[1].v));
    chk("bubbleW", 64'(bubbleW), 64'(!pipe[2].v));
    chk("dstE", 64'(dstE), 64'(pipe[0].d));
    chk("dstM", 64'(dstM), 64'(pipe[1].d));
    chk("dstW", 64'(dstW), 64'(pipe[2].d));
    chk("rdE", rdE, ex_result);
    chk("rdM", rdM, pipe[1].val);
    chk("rdW", rdW, pipe[2].val);
    chk("writeM", 64'(writeM), 64'(pipe[1].v && pipe[1].wen && pipe[1].d != 5'd0));
    chk("writeW", 64'(writeW), 64'(pipe[2].v && pipe[2].wen && pipe[2].d != 5'd0));
    chk("ismemE", 64'(ismemE), 64'(pipe[0].v && pipe[0].ld));
    chk("mem_stall", 64'(mem_stall), 64'(model_frozen()));
    chk("instret", instret, mret);
    chk("scr1", scr1, (ra1 == 5'd0) ? 64'd0 : mrf[ra1]);
    chk("scr2", scr2, (ra2 == 5'd0) ? 64'd0 : mrf[ra2]);
  endtask

  task automatic set_id(input bit v, input bit [4:0] d, input bit wen, input bit ld);
    id_valid = v;
    id_dst   = d;
    id_wen   = wen;
    id_ismem = ld;
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    set_id(0, 5'd0, 0, 0);
    hazard     = 1'b0;
    flush      = 1'b0;
    ex_result  = 64'd0;
    mem_rdata  = 64'd0;
    mem_rvalid = 1'b0;
    ra1        = 5'd0;
    ra2        = 5'd0;
    model_reset();

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("rst_bubbleE", 64'(bubbleE), 64'd1);
    chk("rst_bubbleW", 64'(bubbleW), 64'd1);
    chk("rst_writeW", 64'(writeW), 64'd0);
    chk("rst_instret", instret, 64'd0);
    ra1 = 5'd9;
    ra2 = 5'd31;
    #1;
    chk("rst_scr1", scr1, 64'd0);
    chk("rst_scr2", scr2, 64'd0);
    reset = 1'b1;

    // ALU chain
    set_id(1, 5'd5, 1, 0); ex_result = 64'd0;  settle(); tick();
    set_id(1, 5'd6, 1, 0); ex_result = 64'h11; settle(); tick();
    set_id(0, 5'd0, 0, 0); ex_result = 64'h22; settle();
    chk("alu_dstM", 64'(dstM), 64'd5);
    chk("alu_rdM", rdM, 64'h11);
    chk("alu_writeM", 64'(writeM), 64'd1);
    tick();
    ex_result = 64'd0; settle();
    chk("alu_dstW", 64'(dstW), 64'd5);
    chk("alu_writeW", 64'(writeW), 64'd1);
    tick();
    ra1 = 5'd5; settle();
    chk("alu_scr1", scr1, 64'h11);
    chk("alu_instret", instret, 64'd1);
    tick();

    // Load stall: 3 cycles without data, then data arrives
    set_id(1, 5'd7, 1, 1); settle(); tick();
    set_id(1, 5'd8, 1, 0); ex_result = 64'h33; settle(); tick();
    set_id(1, 5'd9, 1, 0); ex_result = 64'h44; mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("ld_stall_on", 64'(mem_stall), 64'd1);
      chk("ld_hold_dstE", 64'(dstE), 64'd8);
      chk("ld_hold_dstM", 64'(dstM), 64'd7);
      tick();
    end
    mem_rdata = 64'hAB; mem_rvalid = 1'b1; settle();
    chk("ld_stall_off", 64'(mem_stall), 64'd0);
    tick();
    mem_rvalid = 1'b0; set_id(0, 5'd0, 0, 0); settle();
    chk("ld_rdW", rdW, 64'hAB);
    chk("ld_dstW", 64'(dstW), 64'd7);
    tick();
    settle(); tick();

    // Flush during a stall is remembered until release
    set_id(1, 5'd12, 1, 1); settle(); tick();
    set_id(0, 5'd0, 0, 0); settle(); tick();
    set_id(1, 5'd13, 1, 0); flush = 1'b1; settle();
    chk("fl_stall", 64'(mem_stall), 64'd1);
    tick();
    flush = 1'b0; settle();
    chk("fl_stall2", 64'(mem_stall), 64'd1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'hCD; settle(); tick();
    mem_rvalid = 1'b0; set_id(1, 5'd14, 1, 0); settle();
    chk("fl_killed", 64'(bubbleE), 64'd1);
    tick();
    set_id(0, 5'd0, 0, 0); settle();
    chk("fl_next_valid", 64'(bubbleE), 64'd0);
    chk("fl_next_dst", 64'(dstE), 64'd14);
    tick();

    // x0 destination never writes
    set_id(1, 5'd0, 1, 0); settle(); tick();
    set_id(0, 5'd0, 0, 0); ex_result = 64'hFF; settle(); tick();
    settle();
    chk("x0_writeM", 64'(writeM), 64'd0);
    tick();
    settle();
    chk("x0_writeW", 64'(writeW), 64'd0);
    tick();
    ra1 = 5'd0; settle();
    chk("x0_scr1", scr1, 64'd0);
    tick();

    // Hazard bubbles E while M/W advance
    set_id(1, 5'd15, 1, 0); ex_result = 64'h15; settle(); tick();
    set_id(1, 5'd16, 1, 0); hazard = 1'b1; settle(); tick();
    hazard = 1'b0; set_id(0, 5'd0, 0, 0); settle();
    chk("hz_bubbleE", 64'(bubbleE), 64'd1);
    chk("hz_bubbleM", 64'(bubbleM), 64'd0);
    chk("hz_dstM", 64'(dstM), 64'd15);
    tick();

    // Hazard and flush together: one bubble, nothing owed afterwards
    set_id(1, 5'd17, 1, 0); hazard = 1'b1; flush = 1'b1; settle(); tick();
    hazard = 1'b0; flush = 1'b0; set_id(1, 5'd18, 1, 0); settle();
    chk("hzfl_bubbleE", 64'(bubbleE), 64'd1);
    tick();
    set_id(0, 5'd0, 0, 0); settle();
    chk("hzfl_after", 64'(bubbleE), 64'd0);
    tick();

    // Load data present in the very cycle the load reaches M
    set_id(1, 5'd19, 1, 1); settle(); tick();
    set_id(0, 5'd0, 0, 0); settle(); tick();
    mem_rvalid = 1'b1; mem_rdata = 64'h5A; settle();
    chk("rv_nostall", 64'(mem_stall), 64'd0);
    tick();
    mem_rvalid = 1'b0; settle();
    chk("rv_rdW", rdW, 64'h5A);
    chk("rv_dstW", 64'(dstW), 64'd19);
    tick();

    // Reset in the middle of a stall; a late mem_rvalid is ignored
    set_id(1, 5'd20, 1, 1); settle(); tick();
    set_id(0, 5'd0, 0, 0); settle(); tick();
    settle();
    chk("rs_stall", 64'(mem_stall), 64'd1);
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h99; settle();
    chk("rs_nostall", 64'(mem_stall), 64'd0);
    tick();
    mem_rvalid = 1'b0; settle();
    chk("rs_bubbleW", 64'(bubbleW), 64'd1);
    chk("rs_instret", instret, 64'd0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      id_valid   = 1'($urandom_range(0, 1));
      id_dst     = 5'($urandom_range(0, 31));
      id_wen     = ($urandom_range(0, 3) != 0);
      id_ismem   = ($urandom_range(0, 3) == 0);
      hazard     = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      ex_result  = {$urandom, $urandom};
      mem_rdata  = {$urandom, $urandom};
      mem_rvalid = ($urandom_range(0, 2) != 0);
      ra1        = 5'($urandom_range(0, 31));
      ra2        = 5'($urandom_range(0, 31));
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
